// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and defaults for the sprite frame sequencer: FSM state encoding,
// walk-cycle frame count, default sprite geometry and ROM read latency, bus
// field widths, and the frame-advance helper.
// -----------------------------------------------------------------------------
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [1:0] frame_t;

  localparam int NUM_FRAMES           = 3;
  localparam int DEFAULT_SPRITE_W     = 16;
  localparam int DEFAULT_SPRITE_H     = 16;
  localparam int DEFAULT_FRAME_HOLD   = 4;
  localparam int DEFAULT_READ_LATENCY = 2;

  localparam int ROM_W   = 4;
  localparam int ADDR_W  = 16;
  localparam int COORD_W = 8;

  // Walk cycle 0 -> 1 -> ... -> NUM_FRAMES-1 -> 0.
  function automatic frame_t next_frame(input frame_t f);
    return (f == frame_t'(NUM_FRAMES - 1)) ? frame_t'(0) : f + frame_t'(1);
  endfunction

endpackage

// File: rtl/sprite_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// sprite_frame_sequencer_if
// Request/ROM-reader bus of the sprite frame sequencer.
//   start, walking   : draw request and walk-mode select (from the controller)
//   mirror           : horizontal mirror request, only with SPRITE_MIRROR_EN
//   rom, romAddr     : ROM select and pixel address (to the ROM reader)
//   pixelX/Y, Valid  : coordinates aligned to the ROM reader output data
//   busy, done       : draw in progress / one-cycle end-of-draw pulse
// Modports: master = sequencer, slave = controller / ROM-reader side.
// -----------------------------------------------------------------------------
interface sprite_frame_sequencer_if;
  import sprite_pkg::*;

  logic               start;
  logic               walking;
`ifdef SPRITE_MIRROR_EN
  logic               mirror;
`endif
  logic [ROM_W-1:0]   rom;
  logic [ADDR_W-1:0]  romAddr;
  logic [COORD_W-1:0] pixelX;
  logic [COORD_W-1:0] pixelY;
  logic               pixelValid;
  logic               busy;
  logic               done;

  modport master (
    input  start, walking,
    output rom, romAddr, pixelX, pixelY, pixelValid, busy, done
`ifdef SPRITE_MIRROR_EN
    , input mirror
`endif
  );

  modport slave (
    output start, walking,
    input  rom, romAddr, pixelX, pixelY, pixelValid, busy, done
`ifdef SPRITE_MIRROR_EN
    , output mirror
`endif
  );

endinterface

// File: rtl/sprite_valid_pipe.sv
// -----------------------------------------------------------------------------
// sprite_valid_pipe
// LATENCY-deep delay line for the pixel valid flag and its x/y coordinates, so
// they line up with data leaving the ROM reader.
//   clock            : rising-edge clock
//   clear            : synchronous clear of the whole line
//   in_valid/x/y     : issue-cycle values
//   out_valid/x/y    : the same values LATENCY clocks later
// -----------------------------------------------------------------------------
module sprite_valid_pipe
  import sprite_pkg::*;
#(
  parameter int LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y
);

  logic [LATENCY-1:0]              valid_sr;
  logic [LATENCY-1:0][COORD_W-1:0] x_sr;
  logic [LATENCY-1:0][COORD_W-1:0] y_sr;

  always_ff @(posedge clock) begin
    // NOTE: the whole delay line is cleared, not just the head, so no
    // in-flight pixel can surface as valid after a reset.
    if (clear) begin
      valid_sr <= '0;
      x_sr     <= '0;
      y_sr     <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      x_sr[0]     <= in_x;
      y_sr[0]     <= in_y;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        x_sr[i]     <= x_sr[i-1];
        y_sr[i]     <= y_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[LATENCY-1];
  assign out_x     = x_sr[LATENCY-1];
  assign out_y     = y_sr[LATENCY-1];

endmodule

// File: rtl/sprite_frame_sequencer.sv
// -----------------------------------------------------------------------------
// sprite_frame_sequencer
// Scans one sprite frame out of ROM per start request, one address per clock in
// row-major order, and cycles walk frames 0->1->2 every FRAME_HOLD draws.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : sprite_frame_sequencer_if.master (start/walking in, ROM select,
//            address, aligned pixel coordinates, busy/done out)
// Build option: define SPRITE_MIRROR_EN to add the bus mirror input, which
// scans each row right-to-left in ROM while pixelX still reports screen x.
// -----------------------------------------------------------------------------
module sprite_frame_sequencer
  import sprite_pkg::*;
#(
  parameter int SPRITE_W     = DEFAULT_SPRITE_W,
  parameter int SPRITE_H     = DEFAULT_SPRITE_H,
  parameter int FRAME_HOLD   = DEFAULT_FRAME_HOLD,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input logic                      clock,
  input logic                      reset,
  sprite_frame_sequencer_if.master bus
);

  if (SPRITE_W < 1 || SPRITE_W > 255) begin : g_bad_w
    $error("SPRITE_W must be 1..255");
  end
  if (SPRITE_H < 1 || SPRITE_H > 255) begin : g_bad_h
    $error("SPRITE_H must be 1..255");
  end
  if (SPRITE_W * SPRITE_H > 65536) begin : g_bad_area
    $error("SPRITE_W*SPRITE_H exceeds the 16-bit address space");
  end
  if (FRAME_HOLD < 1) begin : g_bad_hold
    $error("FRAME_HOLD must be >= 1");
  end
  if (READ_LATENCY < 1) begin : g_bad_lat
    $error("READ_LATENCY must be >= 1");
  end

  localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(SPRITE_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(SPRITE_H - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);
  // Mirrored scan: from x=0 of row y (addr y*W) to x=W-1 of row y+1.
  localparam logic [ADDR_W-1:0]  ROW_JUMP   = ADDR_W'(2 * SPRITE_W - 1);
  localparam logic [ADDR_W-1:0]  ROW_END    = ADDR_W'(SPRITE_W - 1);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, y_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ROM_W-1:0]   rom_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [HOLD_W-1:0]  hold_q;
  frame_t             frame_q;
  logic               walking_q;
  logic               mirror_in, mirror_q;
  logic               scan_last, drain_last;

`ifdef SPRITE_MIRROR_EN
  assign mirror_in = bus.mirror;
`else
  assign mirror_in = 1'b0;
`endif

  assign scan_last  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign drain_last = (drain_q == DRAIN_LAST);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      rom_q     <= '0;
      drain_q   <= '0;
      hold_q    <= '0;
      frame_q   <= '0;
      walking_q <= 1'b0;
      mirror_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          walking_q <= bus.walking;
          mirror_q  <= mirror_in;
          x_q       <= '0;
          y_q       <= '0;
          addr_q    <= mirror_in ? ROW_END : '0;
          if (bus.walking) begin
            rom_q <= ROM_W'(frame_q);
          end else begin
            // Standing sprite always restarts the walk cycle from scratch.
            frame_q <= '0;
            hold_q  <= '0;
            rom_q   <= '0;
          end
        end
        SCAN: begin
          if (scan_last) begin
            drain_q <= '0;
          end else if (x_q == X_LAST) begin
            x_q    <= '0;
            y_q    <= y_q + 1'b1;
            addr_q <= mirror_q ? addr_q + ROW_JUMP : addr_q + 1'b1;
          end else begin
            x_q    <= x_q + 1'b1;
            addr_q <= mirror_q ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!drain_last) begin
            drain_q <= drain_q + 1'b1;
          end else if (walking_q) begin
            // Transition into DONE: count this completed walk draw.
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              frame_q <= next_frame(frame_q);
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sprite_valid_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_valid_pipe (
    .clock     (clock),
    .clear     (reset),
    .in_valid  (state_q == SCAN),
    .in_x      (x_q),
    .in_y      (y_q),
    .out_valid (bus.pixelValid),
    .out_x     (bus.pixelX),
    .out_y     (bus.pixelY)
  );

  assign bus.rom     = rom_q;
  assign bus.romAddr = addr_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sprite_frame_sequencer
// Directed bench for sprite_frame_sequencer (16x16, FRAME_HOLD=4, latency 2).
// Expected pixels are queued when a draw is requested and popped by a monitor
// whenever pixelValid is seen; addresses, busy/done timing and ROM selects are
// compared inline against a small frame/hold model.
// Define SPRITE_MIRROR_EN to also exercise the mirrored scan.
// -----------------------------------------------------------------------------
module tb_sprite_frame_sequencer;
  import sprite_pkg::*;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int FH = 4;
  localparam int RL = 2;
  localparam int N  = W * H;

  typedef struct {
    int          cyc;
    logic [7:0]  x;
    logic [7:0]  y;
  } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  pix_t sb_q[$];

  int   model_frame = 0;
  int   model_hold  = 0;

  sprite_frame_sequencer_if bus ();

  sprite_frame_sequencer #(
    .SPRITE_W     (W),
    .SPRITE_H     (H),
    .FRAME_HOLD   (FH),
    .READ_LATENCY (RL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] exp_addr(input int k, input bit mir);
    int x, y;
    x = k % W;
    y = k / W;
    return mir ? 16'(y * W + (W - 1 - x)) : 16'(k);
  endfunction

  // Scoreboard consumer: every valid pixel must match the next expected one,
  // including the exact cycle it was due.
  always @(negedge clock) begin
    pix_t e;
    if (bus.pixelValid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("pix_unexpected", 32'(bus.pixelValid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pix_cycle", 32'(cyc), 32'(e.cyc));
        check("pix_x", 32'(bus.pixelX), 32'(e.x));
        check("pix_y", 32'(bus.pixelY), 32'(e.y));
      end
    end
  end

  // One draw. poke_at: address index at which a stray start is pulsed.
  // reset_at: address index at which reset aborts the draw (-1 = none).
  task automatic run_draw(input bit walk, input bit mir, input int poke_at, input int reset_at);
    int          n0;
    logic [3:0]  exp_rom;
    pix_t        p;
    if (!walk) begin
      model_frame = 0;
      model_hold  = 0;
    end
    exp_rom = 4'(model_frame);
    bus.start   = 1'b1;
    bus.walking = walk;
`ifdef SPRITE_MIRROR_EN
    bus.mirror  = mir;
`endif
    step();
    bus.start = 1'b0;
    n0 = cyc;
    check("busy_rise", 32'(bus.busy), 32'd1);
    for (int k = 0; k < N; k++) begin
      p.cyc = n0 + k + RL;
      p.x   = 8'(k % W);
      p.y   = 8'(k / W);
      sb_q.push_back(p);
    end
    for (int k = 0; k < N; k++) begin
      check("rom_addr", 32'(bus.romAddr), 32'(exp_addr(k, mir)));
      check("rom_sel", 32'(bus.rom), 32'(exp_rom));
      check("busy_scan", 32'(bus.busy), 32'd1);
      check("done_scan", 32'(bus.done), 32'd0);
      if (k == reset_at) begin
        reset = 1'b1;
        step();
        sb_q.delete();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.pixelValid), 32'd0);
        check("rst_rom", 32'(bus.rom), 32'd0);
        check("rst_addr", 32'(bus.romAddr), 32'd0);
        reset = 1'b0;
        model_frame = 0;
        model_hold  = 0;
        step();
        check("rst_idle", 32'(bus.busy), 32'd0);
        return;
      end
      bus.start = (k == poke_at);
      step();
    end
    bus.start = 1'b0;
    // DRAIN for RL cycles, DONE for one, then at least two idle cycles.
    for (int j = 0; j <= RL + 2; j++) begin
      check("addr_hold", 32'(bus.romAddr), 32'(exp_addr(N - 1, mir)));
      check("rom_hold", 32'(bus.rom), 32'(exp_rom));
      check("done_tail", 32'(bus.done), (j == RL) ? 32'd1 : 32'd0);
      check("busy_tail", 32'(bus.busy), (j <= RL) ? 32'd1 : 32'd0);
      step();
    end
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    if (walk) begin
      model_hold++;
      if (model_hold == FH) begin
        model_hold  = 0;
        model_frame = (model_frame + 1) % NUM_FRAMES;
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.walking = 1'b0;
`ifdef SPRITE_MIRROR_EN
    bus.mirror  = 1'b0;
`endif
    reset = 1'b1;
    step();
    step();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_valid", 32'(bus.pixelValid), 32'd0);
    check("reset_rom", 32'(bus.rom), 32'd0);
    check("reset_addr", 32'(bus.romAddr), 32'd0);
    check("reset_px", 32'(bus.pixelX), 32'd0);
    check("reset_py", 32'(bus.pixelY), 32'd0);
    reset = 1'b0;
    step();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Standing draw, then one with a stray start mid-scan.
    run_draw(1'b0, 1'b0, -1, -1);
    run_draw(1'b0, 1'b0, 100, -1);

    // 13 back-to-back walk draws: 0,0,0,0,1,1,1,1,2,2,2,2,0.
    for (int d = 0; d < 13; d++) run_draw(1'b1, 1'b0, -1, -1);

    // Reach frame 1, draw it once, then stand: hold count must be cleared.
    for (int d = 0; d < 3; d++) run_draw(1'b1, 1'b0, -1, -1);
    run_draw(1'b1, 1'b0, -1, -1);
    run_draw(1'b0, 1'b0, -1, -1);
    for (int d = 0; d < 8; d++) run_draw(1'b1, 1'b0, -1, -1);

    // Frame 2 draw aborted by reset at address 50, then a fresh draw.
    run_draw(1'b1, 1'b0, -1, 50);
    run_draw(1'b1, 1'b0, -1, -1);

`ifdef SPRITE_MIRROR_EN
    run_draw(1'b0, 1'b1, -1, -1);
    run_draw(1'b0, 1'b0, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
